wb_arbiter_2m: RTL and testbench

WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

---
 rtl/wb_arb_pkg.sv | 23 ++
 rtl/wb_txn_counter.sv | 50 +++++
 rtl/wb_arbiter_2m.sv | 145 ++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the two-master Wishbone arbiter
// Purpose: arbiter state encoding, default outstanding-transaction limit and
//          the bus width macros (XLEN data bits, XLEN_GRAN address bits per word).
// Ports:   none (package).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef XLEN_GRAN
`define XLEN_GRAN 2
`endif

package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT0  = 2'd1,
    ST_GNT1  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  localparam int MAX_OUT_DEFAULT = 4;

endpackage

// File: rtl/wb_txn_counter.sv
// rtl/wb_txn_counter.sv - saturating outstanding-transaction counter with full flag
// Purpose: counts slave transactions accepted but not yet answered.
// Ports:   clk_i, rst_ni   clock, async active-low reset
//          inc_i           a request was accepted by the slave this cycle
//          dec_i           a response (ack or err) arrived this cycle
//          count_o         transactions in flight
//          full_o          count_o == MAX_OUT
import wb_arb_pkg::*;

module wb_txn_counter #(
  parameter  int MAX_OUT = MAX_OUT_DEFAULT,
  localparam int CW      = $clog2(MAX_OUT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          full_o
);

  logic [CW-1:0] count_q, count_d;
  logic          inc_ok, dec_ok;

  assign full_o  = (count_q == CW'(MAX_OUT));
  assign count_o = count_q;

  // A response with nothing in flight is spurious and must not underflow;
  // an accept while full cannot happen upstream but is blocked here too.
  assign dec_ok = dec_i && (count_q != '0);
  assign inc_ok = inc_i && !full_o;

  always_comb begin
    count_d = count_q;
    if (inc_ok && !dec_ok) begin
      count_d = count_q + 1'b1;
    end else if (dec_ok && !inc_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - round-robin arbiter, two pipelined Wishbone masters onto one slave
// Purpose: grants the slave to one master for a whole cyc, limits in-flight
//          transactions to MAX_OUT and drains late responses after release.
// Ports:   clk_i, rst_ni                        clock, async active-low reset
//          m{0,1}_cyc/stb/we/addr/sel/dat_i     master requests
//          m{0,1}_ack/err/stall/dat_o           per-master responses
//          s_cyc/stb/we/addr/sel/dat_o          slave request
//          s_ack/err/stall/dat_i                slave response
import wb_arb_pkg::*;

module wb_arbiter_2m #(
  parameter int MAX_OUT = MAX_OUT_DEFAULT
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         m0_cyc_i,
  input  logic                         m0_stb_i,
  input  logic                         m0_we_i,
  input  logic [`XLEN-`XLEN_GRAN-1:0]  m0_addr_i,
  input  logic [`XLEN/8-1:0]           m0_sel_i,
  input  logic [`XLEN-1:0]             m0_dat_i,
  output logic                         m0_ack_o,
  output logic                         m0_err_o,
  output logic                         m0_stall_o,
  output logic [`XLEN-1:0]             m0_dat_o,
  input  logic                         m1_cyc_i,
  input  logic                         m1_stb_i,
  input  logic                         m1_we_i,
  input  logic [`XLEN-`XLEN_GRAN-1:0]  m1_addr_i,
  input  logic [`XLEN/8-1:0]           m1_sel_i,
  input  logic [`XLEN-1:0]             m1_dat_i,
  output logic                         m1_ack_o,
  output logic                         m1_err_o,
  output logic                         m1_stall_o,
  output logic [`XLEN-1:0]             m1_dat_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  output logic                         s_we_o,
  output logic [`XLEN-`XLEN_GRAN-1:0]  s_addr_o,
  output logic [`XLEN/8-1:0]           s_sel_o,
  output logic [`XLEN-1:0]             s_dat_o,
  input  logic                         s_ack_i,
  input  logic                         s_err_i,
  input  logic                         s_stall_i,
  input  logic [`XLEN-1:0]             s_dat_i
);

  localparam int CW = $clog2(MAX_OUT + 1);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;   // 1 = m1 was granted last, so m0 wins the next tie
  logic [CW-1:0] count;
  logic          full;
  logic          rsp;
  logic          resp_ok;
  logic          drained;
  logic          gnt, g1;

  assign rsp     = s_ack_i || s_err_i;
  assign resp_ok = (count != '0);
  // Counter will read zero after this edge: nothing in flight, or the last one answers now.
  assign drained = (count == '0) || ((count == CW'(1)) && rsp);
  assign gnt     = (state_q == ST_GNT0) || (state_q == ST_GNT1);
  assign g1      = (state_q == ST_GNT1);

  // Read data is broadcast; only the granted master sees ack to qualify it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  wb_txn_counter #(.MAX_OUT(MAX_OUT)) u_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (s_stb_o && !s_stall_i),
    .dec_i   (rsp),
    .count_o (count),
    .full_o  (full)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_addr_o   = '0;
    s_sel_o    = '0;
    s_dat_o    = '0;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m0_stall_o = 1'b1;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    m1_stall_o = 1'b1;

    if (gnt) begin
      s_cyc_o  = g1 ? m1_cyc_i : m0_cyc_i;
      s_stb_o  = s_cyc_o && (g1 ? m1_stb_i : m0_stb_i) && !full;
      s_we_o   = g1 ? m1_we_i   : m0_we_i;
      s_addr_o = g1 ? m1_addr_i : m0_addr_i;
      s_sel_o  = g1 ? m1_sel_i  : m0_sel_i;
      s_dat_o  = g1 ? m1_dat_i  : m0_dat_i;
      if (g1) begin
        m1_stall_o = s_stall_i || full;
        m1_ack_o   = s_ack_i && resp_ok;
        m1_err_o   = s_err_i && resp_ok;
      end else begin
        m0_stall_o = s_stall_i || full;
        m0_ack_o   = s_ack_i && resp_ok;
        m0_err_o   = s_err_i && resp_ok;
      end
      if (!s_cyc_o) begin
        state_d = drained ? ST_IDLE : ST_DRAIN;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
          state_d = ST_GNT0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = ST_GNT1;
          last_d  = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drained) begin
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb/tb_wb_arbiter_2m.sv - self-checking bench for wb_arbiter_2m
`ifndef XLEN
`define XLEN 32
`endif
`ifndef XLEN_GRAN
`define XLEN_GRAN 2
`endif

module tb_wb_arbiter_2m;

  localparam int MAXO = 4;
  localparam int AW   = `XLEN - `XLEN_GRAN;
  localparam int DW   = `XLEN;
  localparam int SW   = `XLEN / 8;

  typedef struct {
    int            due;
    logic [DW-1:0] dat;
    bit            err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic          mc[2], ms[2], mw[2];
  logic [AW-1:0] ma[2];
  logic [SW-1:0] msel[2];
  logic [DW-1:0] md[2];
  logic m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
  logic [DW-1:0] m0_dat, m1_dat;
  logic so_cyc, so_stb, so_we;
  logic [AW-1:0] so_addr;
  logic [SW-1:0] so_sel;
  logic [DW-1:0] so_dat;
  logic s_ack, s_err, s_stall;
  logic [DW-1:0] s_dat;

  always #5 clk = ~clk;

  wb_arbiter_2m #(.MAX_OUT(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_cyc_i(mc[0]), .m0_stb_i(ms[0]), .m0_we_i(mw[0]), .m0_addr_i(ma[0]),
    .m0_sel_i(msel[0]), .m0_dat_i(md[0]),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_stall_o(m0_stall), .m0_dat_o(m0_dat),
    .m1_cyc_i(mc[1]), .m1_stb_i(ms[1]), .m1_we_i(mw[1]), .m1_addr_i(ma[1]),
    .m1_sel_i(msel[1]), .m1_dat_i(md[1]),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_stall_o(m1_stall), .m1_dat_o(m1_dat),
    .s_cyc_o(so_cyc), .s_stb_o(so_stb), .s_we_o(so_we), .s_addr_o(so_addr),
    .s_sel_o(so_sel), .s_dat_o(so_dat),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall), .s_dat_i(s_dat)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model: owner -1 = nobody, draining = late responses still due
  int owner;
  bit draining;
  bit m1_was_last;
  int outst;

  // slave and master environment
  rsp_t          sq[$];
  logic [DW-1:0] mem[int];
  int cyc_n = 0;
  int dly, stall_pct, err_pct;
  bit spur;
  bit            mcyc[2], we_r[2];
  int            left[2], issued[2];
  logic [AW-1:0] base[2];
  logic [SW-1:0] sel_r[2];

  // observations
  int ack_seen[2], acc_cnt[2], acc_cyc[2], ack_cyc[2];
  logic [DW-1:0] rd_dat[2];
  int first_acc, last_acc, dmax, t0;
  bit hold_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
    return DW'(a) * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : mem_init(a);
  endfunction

  function automatic logic [DW-1:0] wdat(input logic [AW-1:0] a);
    return DW'({a, 2'b01}) ^ 32'hC3C3_0000;
  endfunction

  task automatic drive_masters();
    for (int m = 0; m < 2; m++) begin
      mc[m]   = mcyc[m];
      ms[m]   = mcyc[m] && (left[m] > 0);
      ma[m]   = base[m] + AW'(issued[m]);
      mw[m]   = we_r[m];
      msel[m] = we_r[m] ? sel_r[m] : '1;
      md[m]   = wdat(ma[m]);
    end
  endtask

  task automatic start(input int m, input int n, input bit we);
    mcyc[m]   = 1'b1;
    left[m]   = n;
    issued[m] = 0;
    we_r[m]   = we;
    sel_r[m]  = SW'($urandom_range(1, 15));
  endtask

  task automatic clear_stats();
    for (int m = 0; m < 2; m++) begin
      ack_seen[m] = 0;
      acc_cnt[m]  = 0;
    end
    first_acc = -1;
    last_acc  = -1;
    dmax      = 0;
    hold_seen = 1'b0;
  endtask

  // Called at posedge+1 with master intent set; returns at the next posedge+1.
  task automatic step();
    rsp_t r;
    bit e_cyc, e_stb, full, rsp, acc, dec;
    bit [1:0] e_ack, e_err, e_stall;
    logic [DW-1:0] v;
    int nout;
    drive_masters();
    s_stall = ($urandom_range(99) < stall_pct);
    s_ack   = 1'b0;
    s_err   = 1'b0;
    s_dat   = DW'($urandom);
    if (sq.size() > 0 && sq[0].due <= cyc_n) begin
      r     = sq.pop_front();
      s_ack = !r.err;
      s_err = r.err;
      s_dat = r.dat;
    end
    if (spur) begin
      s_ack = 1'b1;
      spur  = 1'b0;
    end
    #1;
    full    = (outst == MAXO);
    rsp     = (outst > 0);
    e_cyc   = 1'b0;
    e_stb   = 1'b0;
    e_ack   = '0;
    e_err   = '0;
    e_stall = 2'b11;
    if (owner >= 0) begin
      e_cyc          = mc[owner];
      e_stb          = mc[owner] && ms[owner] && !full;
      e_stall[owner] = s_stall || full;
      e_ack[owner]   = s_ack && rsp;
      e_err[owner]   = s_err && rsp;
    end
    check("ctl", {m0_ack, m1_ack, m0_err, m1_err, m0_stall, m1_stall, so_cyc, so_stb},
          {e_ack[0], e_ack[1], e_err[0], e_err[1], e_stall[0], e_stall[1], e_cyc, e_stb});
    check("count", 64'(dut.u_cnt.count_o), 64'(outst));
    if (e_stb) begin
      check("req", {so_we, so_sel, so_addr}, {mw[owner], msel[owner], ma[owner]});
      check("wdat", so_dat, md[owner]);
    end
    if (s_ack || s_err) check("rdat", {m0_dat, m1_dat}, {s_dat, s_dat});
    if (m0_ack || m0_err) begin ack_seen[0]++; rd_dat[0] = m0_dat; ack_cyc[0] = cyc_n; end
    if (m1_ack || m1_err) begin ack_seen[1]++; rd_dat[1] = m1_dat; ack_cyc[1] = cyc_n; end
    if (int'(dut.u_cnt.count_o) > dmax) dmax = int'(dut.u_cnt.count_o);

    acc = e_stb && !s_stall;
    dec = (s_ack || s_err) && rsp;
    if (acc) begin
      r.dat = mw[owner] ? '0 : mem_rd(ma[owner]);
      if (mw[owner]) begin
        v = mem_rd(ma[owner]);
        for (int b = 0; b < SW; b++) if (msel[owner][b]) v[b*8 +: 8] = md[owner][b*8 +: 8];
        mem[int'(ma[owner])] = v;
      end
      r.due = cyc_n + dly;
      r.err = ($urandom_range(99) < err_pct);
      sq.push_back(r);
      left[owner]--;
      issued[owner]++;
      acc_cnt[owner]++;
      acc_cyc[owner] = cyc_n;
      last_acc = owner;
      if (first_acc < 0) first_acc = owner;
      if (dec && outst == 2) hold_seen = 1'b1;
    end
    nout = outst + (acc ? 1 : 0) - (dec ? 1 : 0);
    if (owner >= 0) begin
      if (!mc[owner]) begin
        draining = (nout != 0);
        owner    = -1;
      end
    end else if (draining) begin
      if (nout == 0) draining = 1'b0;
    end else if (mc[0] && (!mc[1] || m1_was_last)) begin
      owner = 0; m1_was_last = 1'b0;
    end else if (mc[1]) begin
      owner = 1; m1_was_last = 1'b1;
    end
    outst = nout;
    @(posedge clk);
    cyc_n++;
    #1;
  endtask

  task automatic do_reset();
    s_ack   = 1'b0;
    s_err   = 1'b0;
    s_stall = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("rst_ctl", {m0_ack, m1_ack, m0_err, m1_err, m0_stall, m1_stall, so_cyc, so_stb},
          8'b0000_1100);
    check("rst_count", 64'(dut.u_cnt.count_o), 0);
    owner = -1; draining = 1'b0; m1_was_last = 1'b1; outst = 0;
    sq.delete();
    for (int m = 0; m < 2; m++) begin
      mcyc[m] = 1'b0; left[m] = 0; issued[m] = 0; we_r[m] = 1'b0;
    end
    drive_masters();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input int m, input int n);
    for (int i = 0; i < 200 && ack_seen[m] < n; i++) step();
    check("wait_ack", 64'(ack_seen[m] >= n), 1);
  endtask

  task automatic wait_acc(input int m, input int n);
    for (int i = 0; i < 200 && acc_cnt[m] < n; i++) step();
    check("wait_acc", 64'(acc_cnt[m] >= n), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0; s_dat = '0; spur = 1'b0;
    dly = 1; stall_pct = 0; err_pct = 0;
    for (int m = 0; m < 2; m++) begin
      mcyc[m] = 1'b0; left[m] = 0; issued[m] = 0; we_r[m] = 1'b0; base[m] = '0; sel_r[m] = '1;
    end
    drive_masters();
    @(posedge clk);
    #1;

    // simultaneous requests after reset: m0 wins, read of 0x10
    do_reset();
    clear_stats();
    base[0] = AW'(32'h10); base[1] = AW'(32'h20);
    start(0, 1, 1'b0); start(1, 1, 1'b0);
    t0 = cyc_n;
    wait_ack(0, 1);
    check("s028_gnt_lat", 64'(acc_cyc[0] - t0), 1);
    check("s028_ack_lat", 64'(ack_cyc[0] - acc_cyc[0]), 1);
    check("s028_rdat", rd_dat[0], mem_init(AW'(32'h10)));
    check("s028_m1_quiet", 64'(ack_seen[1]), 0);

    // round robin: m0 re-requests while m1 waits, m1 wins
    mcyc[0] = 1'b0;
    step();
    base[0] = AW'(32'h30);
    start(0, 1, 1'b0);
    clear_stats();
    wait_acc(1, 1);
    check("s029_rr", 64'(first_acc), 1);
    wait_ack(1, 1);
    mcyc[1] = 1'b0;
    wait_ack(0, 1);
    check("s029_then_m0", 64'(last_acc), 0);
    mcyc[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      clear_stats();
      start(1, 1, 1'b0);
      wait_ack(1, 1);
      check("s029_m1_alone", 64'(first_acc), 1);
      mcyc[1] = 1'b0;
    end

    // outstanding limit with slow slave
    do_reset();
    clear_stats();
    dly = 6;
    base[0] = AW'(32'h100);
    start(0, 6, 1'b0);
    wait_ack(0, 1);
    check("s030_acc_before_ack", 64'(acc_cnt[0]), 4);
    check("s030_max_out", 64'(dmax), 4);
    wait_ack(0, 6);
    check("s030_all_acc", 64'(acc_cnt[0]), 6);
    check("s030_max_final", 64'(dmax), 4);
    mcyc[0] = 1'b0;
    step();

    // m1 abandons with 2 outstanding: drained silently, then m0
    do_reset();
    clear_stats();
    dly = 5;
    base[1] = AW'(32'h40);
    start(1, 2, 1'b0);
    wait_acc(1, 2);
    mcyc[1] = 1'b0;
    base[0] = AW'(32'h50);
    start(0, 1, 1'b0);
    clear_stats();
    wait_ack(0, 1);
    check("s031_m1_no_fwd", 64'(ack_seen[1]), 0);
    check("s031_m0_once", 64'(ack_seen[0]), 1);
    check("s031_m0_rdat", rd_dat[0], mem_init(AW'(32'h50)));
    mcyc[0] = 1'b0;
    step();

    // same-cycle accept/ack at 2 outstanding, then a spurious ack
    do_reset();
    clear_stats();
    dly = 2;
    base[0] = AW'(32'h200);
    start(0, 4, 1'b0);
    wait_ack(0, 4);
    check("s032_hold_hit", 64'(hold_seen), 1);
    mcyc[0] = 1'b0;
    step();
    step();
    clear_stats();
    spur = 1'b1;
    step();
    step();
    check("s032_spur_fwd", 64'(ack_seen[0] + ack_seen[1]), 0);
    check("s032_spur_cnt", 64'(dut.u_cnt.count_o), 0);

    // reset mid-burst with 3 outstanding
    do_reset();
    clear_stats();
    dly = 8;
    base[0] = AW'(32'h300);
    start(0, 5, 1'b1);
    wait_acc(0, 3);
    check("s033_pre_cnt", 64'(dut.u_cnt.count_o), 3);
    do_reset();
    clear_stats();
    dly = 1;
    base[0] = AW'(32'h310); base[1] = AW'(32'h320);
    start(0, 1, 1'b0); start(1, 1, 1'b0);
    for (int i = 0; i < 20 && first_acc < 0; i++) step();
    check("s033_m0_prio", 64'(first_acc), 0);
    wait_ack(0, 1);
    mcyc[0] = 1'b0;
    wait_ack(1, 1);
    mcyc[1] = 1'b0;
    step();

    // randomized traffic against the model
    do_reset();
    clear_stats();
    stall_pct = 25;
    err_pct   = 10;
    for (int c = 0; c < 800; c++) begin
      dly = $urandom_range(4);
      for (int m = 0; m < 2; m++) begin
        if (!mcyc[m]) begin
          if ($urandom_range(3) == 0) begin
            base[m] = AW'($urandom_range(255));
            start(m, $urandom_range(1, 4), 1'($urandom_range(1)));
          end
        end else if (left[m] == 0 && $urandom_range(2) == 0) begin
          mcyc[m] = 1'b0;
        end
      end
      if ($urandom_range(49) == 0) spur = 1'b1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
